// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared types and defaults for the I2C command sequencer.
//   state_t : sequencer FSM states
//   cmd_t   : queued host command {rw, addr, data}
package i2c_seq_pkg;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 4096;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } cmd_t;
endpackage

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo: command queue, DEPTH entries, pointers with extra wrap bit.
//   clk/rst     : clock, async active-low reset
//   push/din    : write side (ignored when full)
//   pop/dout    : read side, dout shows head (ignored when empty)
//   full/empty  : flags derived from registered pointers
module i2c_cmd_fifo
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    cmd_t          mem [DEPTH];
    logic [AW:0]   wp, rp;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];
    always_ff @(posedge clk)
        if (push && !full) mem[wp[AW-1:0]] <= din;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: queues host I2C commands and runs them one at a time on the I2C top.
//   clk/rst            : clock, async active-low reset
//   cmd_*              : host command input (valid/ready)
//   i2c_*              : transaction interface to the I2C top
//   rsp_*              : host response output (valid/ready), rsp_err = timeout
//   busy               : FSM active or commands pending
module i2c_cmd_seq
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       i2c_start,
    output logic       i2c_wr,
    output logic [6:0] i2c_addr,
    output logic [7:0] i2c_din,
    input  logic       i2c_done,
    input  logic [7:0] i2c_datard,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);
    localparam int CW = $clog2(TIMEOUT);
    state_t        state;
    logic [CW-1:0] cnt;
    logic          full, empty, pop;
    cmd_t          head;
    // ready is forced low while reset is asserted
    assign cmd_ready = rst && !full;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = (state != IDLE) || !empty;
    i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (cmd_valid && cmd_ready),
        .din  ({cmd_rw, cmd_addr, cmd_data}),
        .pop  (pop),
        .dout (head),
        .full (full),
        .empty(empty)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            i2c_start <= 1'b0;
            i2c_wr    <= 1'b0;
            i2c_addr  <= '0;
            i2c_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            i2c_start <= 1'b0;
            case (state)
                IDLE: if (!empty) begin
                    i2c_wr   <= head.rw;
                    i2c_addr <= head.addr;
                    i2c_din  <= head.data;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    i2c_start <= 1'b1;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                // done is checked first so it wins over a coincident timeout
                WAIT: if (i2c_done) begin
                    rsp_data  <= i2c_wr ? 8'h00 : i2c_datard;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    rsp_data  <= 8'h00;
                    rsp_err   <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_cmd_seq.sv
// tb_i2c_cmd_seq: scoreboard bench for the I2C command sequencer.
module tb_i2c_cmd_seq;
    import i2c_seq_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    logic       cmd_valid = 0, cmd_ready, cmd_rw = 0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       i2c_start, i2c_wr, i2c_done = 0;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_din, i2c_datard = '0;
    logic       rsp_valid, rsp_ready = 0, rsp_err, busy;
    logic [7:0] rsp_data;
    logic       t_cmd_valid = 0, t_cmd_ready, t_cmd_rw = 0;
    logic [6:0] t_cmd_addr = '0;
    logic [7:0] t_cmd_data = '0;
    logic       t_i2c_start, t_i2c_wr, t_i2c_done = 0;
    logic [6:0] t_i2c_addr;
    logic [7:0] t_i2c_din, t_i2c_datard = '0;
    logic       t_rsp_valid, t_rsp_ready = 0, t_rsp_err, t_busy;
    logic [7:0] t_rsp_data;
    i2c_cmd_seq #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .i2c_start(i2c_start), .i2c_wr(i2c_wr), .i2c_addr(i2c_addr), .i2c_din(i2c_din),
        .i2c_done(i2c_done), .i2c_datard(i2c_datard), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );
    i2c_cmd_seq #(.DEPTH(4), .TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
        .cmd_rw(t_cmd_rw), .cmd_addr(t_cmd_addr), .cmd_data(t_cmd_data),
        .i2c_start(t_i2c_start), .i2c_wr(t_i2c_wr), .i2c_addr(t_i2c_addr), .i2c_din(t_i2c_din),
        .i2c_done(t_i2c_done), .i2c_datard(t_i2c_datard), .rsp_valid(t_rsp_valid),
        .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err), .busy(t_busy)
    );
    int         n_tests = 0;
    int         n_fail = 0;
    cmd_t       exp_cmd[$];
    logic [8:0] exp_rsp[$];
    logic       cur_rw = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d, output logic acc);
        cmd_valid = 1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
        acc = cmd_ready;
        if (acc) exp_cmd.push_back({rw, a, d});
        @(negedge clk);
        cmd_valid = 0;
    endtask
    task automatic wait_start(output int cyc);
        cmd_t c;
        cyc = 0;
        while (!i2c_start && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("start_seen", i2c_start, 1);
        if (exp_cmd.size() == 0) chk("cmd_queue", 0, 1);
        else begin
            c = exp_cmd.pop_front();
            chk("i2c_wr", i2c_wr, c.rw);
            chk("i2c_addr", i2c_addr, c.addr);
            chk("i2c_din", i2c_din, c.data);
            cur_rw = c.rw;
        end
        @(negedge clk);
        chk("start_pulse", i2c_start, 0);
    endtask
    task automatic do_done(input logic [7:0] d);
        i2c_datard = d;
        i2c_done = 1;
        exp_rsp.push_back({1'b0, cur_rw ? 8'h00 : d});
        @(negedge clk);
        i2c_done = 0;
        i2c_datard = 8'hEE;
    endtask
    task automatic get_rsp(input int hold);
        int cyc;
        logic [8:0] e;
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rsp_seen", rsp_valid, 1);
        if (exp_rsp.size() == 0) chk("rsp_queue", 0, 1);
        else begin
            e = exp_rsp.pop_front();
            chk("rsp_data", rsp_data, e[7:0]);
            chk("rsp_err", rsp_err, e[8]);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", rsp_valid, 1);
                chk("hold_data", rsp_data, e[7:0]);
                chk("hold_no_start", i2c_start, 0);
            end
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_drop", rsp_valid, 0);
    endtask
    initial begin
        int   cyc;
        logic acc;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_i2c", {i2c_start, i2c_wr, i2c_addr, i2c_din}, 0);
        rst = 1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        // write into idle block, done 40 cycles after start
        push_cmd(1, 7'h50, 8'hA5, acc);
        chk("w_acc", acc, 1);
        chk("w_busy", busy, 1);
        wait_start(cyc);
        chk("w_latency", cyc, 2);
        repeat (38) @(negedge clk);
        chk("w_wait_no_rsp", rsp_valid, 0);
        do_done(8'h5A);
        get_rsp(0);
        chk("w_idle", busy, 0);
        chk("w_hold_addr", i2c_addr, 7'h50);
        // read
        push_cmd(0, 7'h3C, 8'h11, acc);
        wait_start(cyc);
        repeat (5) @(negedge clk);
        do_done(8'h7E);
        get_rsp(0);
        // done outside WAIT is ignored
        i2c_done = 1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_done_ignored", rsp_valid, 0);
        end
        i2c_done = 0;
        // fill FIFO while stalled in WAIT
        push_cmd(1, 7'h01, 8'h02, acc);
        wait_start(cyc);
        for (int i = 0; i < 5; i++) begin
            push_cmd(0, 7'h20 + 7'(i), 8'h00, acc);
            chk("fill_acc", acc, i < 4);
        end
        chk("full_ready", cmd_ready, 0);
        do_done(8'h33);
        get_rsp(0);
        for (int i = 0; i < 4; i++) begin
            wait_start(cyc);
            do_done(8'h40 + 8'(i));
            get_rsp(0);
        end
        chk("drain_idle", busy, 0);
        // response held while host stalls, next command waits
        push_cmd(1, 7'h12, 8'h34, acc);
        push_cmd(0, 7'h13, 8'h00, acc);
        wait_start(cyc);
        do_done(8'h00);
        get_rsp(10);
        wait_start(cyc);
        chk("next_after_hs", cyc <= 3, 1);
        do_done(8'hC3);
        get_rsp(0);
        // timeout with TIMEOUT=16
        t_cmd_valid = 1; t_cmd_rw = 1; t_cmd_addr = 7'h11; t_cmd_data = 8'h22;
        @(negedge clk);
        t_cmd_valid = 0;
        cyc = 0;
        while (!t_i2c_start && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t_start", t_i2c_start, 1);
        chk("t_addr", t_i2c_addr, 7'h11);
        cyc = 0;
        while (!t_rsp_valid && cyc < 100) begin @(negedge clk); cyc++; end
        chk("t_timeout_cycles", cyc, 16);
        chk("t_err", t_rsp_err, 1);
        chk("t_data", t_rsp_data, 0);
        t_rsp_ready = 1;
        @(negedge clk);
        t_rsp_ready = 0;
        // done coincident with timeout
        t_cmd_valid = 1; t_cmd_rw = 0; t_cmd_addr = 7'h12;
        @(negedge clk);
        t_cmd_valid = 0;
        cyc = 0;
        while (!t_i2c_start && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t2_start", t_i2c_start, 1);
        repeat (15) @(negedge clk);
        chk("t2_no_early_rsp", t_rsp_valid, 0);
        t_i2c_done = 1; t_i2c_datard = 8'h99;
        @(negedge clk);
        t_i2c_done = 0;
        chk("t2_valid", t_rsp_valid, 1);
        chk("t2_err", t_rsp_err, 0);
        chk("t2_data", t_rsp_data, 8'h99);
        t_rsp_ready = 1;
        @(negedge clk);
        t_rsp_ready = 0;
        // reset during WAIT with two queued
        push_cmd(0, 7'h55, 8'h00, acc);
        wait_start(cyc);
        push_cmd(1, 7'h56, 8'h01, acc);
        push_cmd(1, 7'h57, 8'h02, acc);
        chk("pre_rst_busy", busy, 1);
        rst = 0;
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", cmd_ready, 0);
        chk("arst_i2c", {i2c_start, i2c_wr, i2c_addr, i2c_din}, 0);
        chk("arst_rsp", {rsp_err, rsp_data}, 0);
        exp_cmd.delete();
        @(negedge clk);
        rst = 1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_quiet", {rsp_valid, i2c_start, busy}, 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
